// File: rtl/kypd_pkg.sv
// Shared definitions for the 4x4 keypad scanner: debounce FSM encoding, key map
// table, parameter defaults and small lookup helpers.
package kypd_pkg;

   localparam int SCAN_DIV_DEFAULT       = 100000;
   localparam int DEBOUNCE_SCANS_DEFAULT = 4;

   localparam logic [1:0] ST_IDLE        = 2'd0;
   localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
   localparam logic [1:0] ST_HELD        = 2'd2;
   localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

   // Nibble index is {column, row}; nibble 0 is column 0 / row 0 (key 1).
   localparam logic [15:0][3:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

   typedef struct packed {
      logic       hit;
      logic [3:0] code;
   } pass_result_t;

   function automatic logic [3:0] key_lookup(input logic [1:0] col, input logic [1:0] row);
      return KEY_MAP[{col, row}];
   endfunction

   // Lowest-numbered active-low row wins so multi-key presses resolve deterministically.
   function automatic logic [1:0] first_low_row(input logic [3:0] rows_n);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows_n[i]) begin
            idx = 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/kypd_row_sync.sv
// Two-flop synchronizer for the active-low keypad row lines; resets to the idle
// (all released) pattern so no phantom key is seen coming out of reset.
module kypd_row_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rows_async,
   output logic [3:0] rows_sync
);

   logic [3:0] meta_reg;
   logic [3:0] sync_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_reg <= 4'b1111;
         sync_reg <= 4'b1111;
      end else begin
         meta_reg <= rows_async;
         sync_reg <= meta_reg;
      end
   end

   assign rows_sync = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: steps an active-low column drive, captures the first
// pressed key of each full scan pass and debounces press/release over whole passes.
module keypad_scanner
   import kypd_pkg::*;
#(
   parameter int SCAN_DIV       = SCAN_DIV_DEFAULT,
   parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_release,
   output logic       key_held
);

   localparam int               DIV_W      = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       AGREE_DONE = 4'(DEBOUNCE_SCANS);

   logic [3:0]       rows_sync;
   logic [DIV_W-1:0] div_reg, div_next;
   logic [1:0]       col_idx_reg, col_idx_next;
   logic             sample_tick;
   logic             pass_done;
   pass_result_t     pass_reg, pass_next, pass_result;
   logic [1:0]       state_reg, state_next;
   logic [3:0]       agree_reg, agree_next;
   logic [3:0]       cand_reg, cand_next;
   logic [3:0]       key_code_reg, key_code_next;
   logic             key_valid_reg, key_valid_next;
   logic             key_release_reg, key_release_next;

   kypd_row_sync u_row_sync (
      .clk        (clk),
      .rst        (rst),
      .rows_async (rows),
      .rows_sync  (rows_sync)
   );

   // Column timing: each column is driven for SCAN_DIV cycles and sampled on the last one,
   // leaving the synchronizer plenty of settling time after the column switches.
   assign sample_tick  = (div_reg == DIV_LAST);
   assign pass_done    = sample_tick && (col_idx_reg == 2'd3);
   assign div_next     = sample_tick ? '0 : div_reg + DIV_W'(1);
   assign col_idx_next = sample_tick ? col_idx_reg + 2'd1 : col_idx_reg;

   for (genvar gi = 0; gi < 4; gi++) begin : g_col_drive
      assign cols[gi] = (col_idx_reg != 2'(gi));
   end

   // pass_result merges the current sample into the running pass so the FSM sees the
   // complete pass on the column-3 sample cycle, while the register clears for the next pass.
   always_comb begin
      pass_result = pass_reg;
      if (sample_tick && !pass_reg.hit && (rows_sync != 4'b1111)) begin
         pass_result.hit  = 1'b1;
         pass_result.code = key_lookup(col_idx_reg, first_low_row(rows_sync));
      end
      pass_next = pass_done ? '0 : pass_result;
   end

   always_comb begin
      state_next       = state_reg;
      agree_next       = agree_reg;
      cand_next        = cand_reg;
      key_code_next    = key_code_reg;
      key_valid_next   = 1'b0;
      key_release_next = 1'b0;
      if (pass_done) begin
         case (state_reg)
            ST_IDLE: begin
               if (pass_result.hit) begin
                  cand_next  = pass_result.code;
                  agree_next = 4'd1;
                  state_next = ST_PRESS_CHK;
               end
            end
            ST_PRESS_CHK: begin
               if (!pass_result.hit) begin
                  agree_next = 4'd0;
                  state_next = ST_IDLE;
               end else if (pass_result.code != cand_reg) begin
                  cand_next  = pass_result.code;
                  agree_next = 4'd1;
               end else begin
                  agree_next = agree_reg + 4'd1;
                  if (agree_reg + 4'd1 >= AGREE_DONE) begin
                     state_next     = ST_HELD;
                     key_code_next  = cand_reg;
                     key_valid_next = 1'b1;
                  end
               end
            end
            ST_HELD: begin
               // Any hit keeps the key held; a second key never generates a new press.
               if (!pass_result.hit) begin
                  agree_next = 4'd1;
                  state_next = ST_RELEASE_CHK;
               end
            end
            ST_RELEASE_CHK: begin
               if (pass_result.hit) begin
                  state_next = ST_HELD;
               end else begin
                  agree_next = agree_reg + 4'd1;
                  if (agree_reg + 4'd1 >= AGREE_DONE) begin
                     agree_next       = 4'd0;
                     state_next       = ST_IDLE;
                     key_release_next = 1'b1;
                  end
               end
            end
            default: begin
               state_next = ST_IDLE;
               agree_next = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_reg         <= '0;
         col_idx_reg     <= 2'd0;
         pass_reg        <= '0;
         state_reg       <= ST_IDLE;
         agree_reg       <= 4'd0;
         cand_reg        <= 4'h0;
         key_code_reg    <= 4'h0;
         key_valid_reg   <= 1'b0;
         key_release_reg <= 1'b0;
      end else begin
         div_reg         <= div_next;
         col_idx_reg     <= col_idx_next;
         pass_reg        <= pass_next;
         state_reg       <= state_next;
         agree_reg       <= agree_next;
         cand_reg        <= cand_next;
         key_code_reg    <= key_code_next;
         key_valid_reg   <= key_valid_next;
         key_release_reg <= key_release_next;
      end
   end

   assign key_code    = key_code_reg;
   assign key_valid   = key_valid_reg;
   assign key_release = key_release_reg;
   assign key_held    = (state_reg == ST_HELD) || (state_reg == ST_RELEASE_CHK);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a pass-aligned step table of key patterns with
// expected strobe counts and outputs, plus hand-written reset and idle-scan sequences.
module tb_keypad_scanner;

   localparam int SCAN_DIV    = 4;
   localparam int DEB         = 3;
   localparam int PASS_CYCLES = 4 * SCAN_DIV;

   // Key bit index is column*4 + row.
   localparam logic [15:0] K_NONE = 16'h0000;
   localparam logic [15:0] K_1    = 16'h0001;
   localparam logic [15:0] K_5    = 16'h0020;
   localparam logic [15:0] K_9    = 16'h0400;
   localparam logic [15:0] K_D    = 16'h8000;

   typedef struct {
      string       name;
      logic [15:0] keys;
      int          passes;
      int          exp_valid;
      int          exp_release;
      logic        exp_held;
      logic [3:0]  exp_code;
   } step_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_release;
   logic        key_held;
   logic [15:0] keys = 16'h0000;

   int    checks = 0;
   int    errors = 0;
   int    valid_cnt;
   int    release_cnt;
   step_t steps[20];
   int    n_steps = 0;

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rows        (rows),
      .cols        (cols),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_release (key_release),
      .key_held    (key_held)
   );

   always #5 clk = ~clk;

   // Keypad matrix model: a pressed key shorts its row to its column while that column is driven low.
   always_comb begin
      rows = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[c*4 + r] && !cols[c]) begin
               rows[r] = 1'b0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic add_step(input string nm, input logic [15:0] k, input int p, input int v,
                           input int r, input logic h, input logic [3:0] c);
      step_t s;
      s.name        = nm;
      s.keys        = k;
      s.passes      = p;
      s.exp_valid   = v;
      s.exp_release = r;
      s.exp_held    = h;
      s.exp_code    = c;
      steps[n_steps] = s;
      n_steps++;
   endtask

   // Always entered on a negedge that starts a scan pass; leaves on the negedge starting the next one.
   task automatic run_passes(input int n);
      valid_cnt   = 0;
      release_cnt = 0;
      for (int i = 0; i < n * PASS_CYCLES; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) valid_cnt++;
         if (key_release === 1'b1) release_cnt++;
      end
   endtask

   task automatic do_reset();
      valid_cnt   = 0;
      release_cnt = 0;
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (key_valid === 1'b1) valid_cnt++;
         if (key_release === 1'b1) release_cnt++;
      end
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".cols"}, 32'(cols), 32'(4'b1110));
      check({tag, ".code"}, 32'(key_code), 32'(4'h0));
      check({tag, ".valid"}, 32'(key_valid), 32'(1'b0));
      check({tag, ".release"}, 32'(key_release), 32'(1'b0));
      check({tag, ".held"}, 32'(key_held), 32'(1'b0));
      check({tag, ".strobes"}, 32'(valid_cnt + release_cnt), 32'(0));
   endtask

   task automatic apply_step(input step_t s);
      keys = s.keys;
      run_passes(s.passes);
      $display("step %-14s keys=%h passes=%0d valid=%0d release=%0d held=%b code=%h",
               s.name, s.keys, s.passes, valid_cnt, release_cnt, key_held, key_code);
      check({s.name, ".valid"}, 32'(valid_cnt), 32'(s.exp_valid));
      check({s.name, ".release"}, 32'(release_cnt), 32'(s.exp_release));
      check({s.name, ".held"}, 32'(key_held), 32'(s.exp_held));
      check({s.name, ".code"}, 32'(key_code), 32'(s.exp_code));
   endtask

   initial begin
      logic [3:0] exp_cols;
      step_t      s;

      add_step("k5_wait",      K_5,       2, 0, 0, 1'b0, 4'h0);
      add_step("k5_accept",    K_5,       1, 1, 0, 1'b1, 4'h5);
      add_step("k5_hold",      K_5,       3, 0, 0, 1'b1, 4'h5);
      add_step("k5_rel_wait",  K_NONE,    2, 0, 0, 1'b1, 4'h5);
      add_step("k5_release",   K_NONE,    1, 0, 1, 1'b0, 4'h5);
      add_step("idle",         K_NONE,    2, 0, 0, 1'b0, 4'h5);
      add_step("k9_pre",       K_9,       2, 0, 0, 1'b0, 4'h5);
      add_step("k9_drop",      K_NONE,    1, 0, 0, 1'b0, 4'h5);
      add_step("k9_restart",   K_9,       2, 0, 0, 1'b0, 4'h5);
      add_step("k9_accept",    K_9,       1, 1, 0, 1'b1, 4'h9);
      add_step("k9_release",   K_NONE,    3, 0, 1, 1'b0, 4'h9);
      add_step("k1d_accept",   K_1 | K_D, 3, 1, 0, 1'b1, 4'h1);
      add_step("d_only",       K_D,       4, 0, 0, 1'b1, 4'h1);
      add_step("d_release",    K_NONE,    3, 0, 1, 1'b0, 4'h1);
      add_step("k5_cand",      K_5,       1, 0, 0, 1'b0, 4'h1);
      add_step("k9_reload",    K_9,       2, 0, 0, 1'b0, 4'h1);
      add_step("k9_accept2",   K_9,       1, 1, 0, 1'b1, 4'h9);
      add_step("k9_bounce_up", K_NONE,    2, 0, 0, 1'b1, 4'h9);
      add_step("k9_bounce_dn", K_9,       1, 0, 0, 1'b1, 4'h9);
      add_step("k9_release2",  K_NONE,    3, 0, 1, 1'b0, 4'h9);

      // Reset then 20 idle passes: column walks every SCAN_DIV clocks, no strobes.
      do_reset();
      check_reset_outputs("por");
      valid_cnt   = 0;
      release_cnt = 0;
      for (int j = 1; j <= 20 * PASS_CYCLES; j++) begin
         @(negedge clk);
         exp_cols = 4'b1111;
         exp_cols[(j / SCAN_DIV) % 4] = 1'b0;
         check("idle_cols", 32'(cols), 32'(exp_cols));
         if (key_valid === 1'b1) valid_cnt++;
         if (key_release === 1'b1) release_cnt++;
      end
      $display("idle scan done: valid=%0d release=%0d held=%b code=%h",
               valid_cnt, release_cnt, key_held, key_code);
      check("idle.strobes", 32'(valid_cnt + release_cnt), 32'(0));
      check("idle.held", 32'(key_held), 32'(1'b0));
      check("idle.code", 32'(key_code), 32'(4'h0));

      for (int i = 0; i < n_steps; i++) begin
         apply_step(steps[i]);
      end

      // Reset in the middle of press debounce: no strobe, key re-accepted through full debounce.
      keys = K_5;
      run_passes(2);
      check("rstp.pre_valid", 32'(valid_cnt), 32'(0));
      do_reset();
      $display("reset during press check: held=%b code=%h", key_held, key_code);
      check_reset_outputs("rstp");
      s.name = "rstp_wait";   s.keys = K_5; s.passes = 2; s.exp_valid = 0; s.exp_release = 0;
      s.exp_held = 1'b0; s.exp_code = 4'h0;
      apply_step(s);
      s.name = "rstp_accept"; s.passes = 1; s.exp_valid = 1; s.exp_held = 1'b1; s.exp_code = 4'h5;
      apply_step(s);

      // Reset in the middle of release debounce with the key pressed again.
      keys = K_NONE;
      run_passes(2);
      check("rstr.pre_release", 32'(release_cnt), 32'(0));
      check("rstr.pre_held", 32'(key_held), 32'(1'b1));
      keys = K_5;
      do_reset();
      $display("reset during release check: held=%b code=%h", key_held, key_code);
      check_reset_outputs("rstr");
      s.name = "rstr_wait";   s.keys = K_5; s.passes = 2; s.exp_valid = 0; s.exp_release = 0;
      s.exp_held = 1'b0; s.exp_code = 4'h0;
      apply_step(s);
      s.name = "rstr_accept"; s.passes = 1; s.exp_valid = 1; s.exp_held = 1'b1; s.exp_code = 4'h5;
      apply_step(s);
      s.name = "rstr_release"; s.keys = K_NONE; s.passes = 3; s.exp_valid = 0; s.exp_release = 1;
      s.exp_held = 1'b0; s.exp_code = 4'h5;
      apply_step(s);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000, sets clk cycles each column is driven (1 ms at 100 MHz); legal range 4..2^20.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, sets consecutive agreeing full scan passes needed to accept a press or release; legal range 2..15.
REQ-003 clk  input  1  single 100 MHz system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rows  input  4  keypad row lines, active-low (pulled up), asynchronous to clk.
REQ-006 cols  output  4  keypad column drive, one-hot active-low.
REQ-007 key_code  output  4  hex value of the last accepted key; holds until the next accept.
REQ-008 key_valid  output  1  one-cycle strobe on press acceptance.
REQ-009 key_release  output  1  one-cycle strobe on release acceptance.
REQ-010 key_held  output  1  high while a key is accepted and not yet released.

Function
REQ-011 rows SHALL pass through a 2-flop synchronizer before any use; synchronizer reset value 4'b1111.
REQ-012 Divider SHALL count 0..SCAN_DIV-1 and wrap; its terminal cycle is the sample cycle.
REQ-013 On each sample cycle the synchronized rows SHALL be sampled for the current column, then the column index SHALL advance 0->1->2->3->0; cols = ~(1 << index).
REQ-014 Key map, (column, row 0..3): col0 = 1,4,7,0; col1 = 2,5,8,F; col2 = 3,6,9,E; col3 = A,B,C,D.
REQ-015 A scan pass is the four samples for columns 0..3; the pass result is hit/no-hit plus the code of the first low row found (lowest column first, then lowest row), so multi-key presses resolve deterministically.
REQ-016 Pass results SHALL be evaluated on the column-3 sample cycle; the per-pass hit and code registers SHALL clear for the next pass in that same cycle.
REQ-017 FSM states: IDLE, PRESS_CHK, HELD, RELEASE_CHK; a 4-bit agree counter tracks consecutive passes.
REQ-018 IDLE: a hit pass loads the candidate code, sets counter = 1, and moves to PRESS_CHK; a no-hit pass stays in IDLE.
REQ-019 PRESS_CHK: a same-code hit increments the counter; on reaching DEBOUNCE_SCANS it moves to HELD, loads key_code, and pulses key_valid.
REQ-020 PRESS_CHK: a different-code hit reloads the candidate and sets counter = 1; a no-hit pass returns to IDLE with no strobe.
REQ-021 HELD: a no-hit pass moves to RELEASE_CHK with counter = 1; any hit pass, including a different code, stays in HELD with no new key_valid.
REQ-022 RELEASE_CHK: a no-hit pass increments the counter; on reaching DEBOUNCE_SCANS it moves to IDLE and pulses key_release; any hit pass returns to HELD with no strobe.
REQ-023 Strobes SHALL be registered: asserted exactly the one cycle after the deciding sample cycle, never back-to-back.
REQ-024 key_held SHALL be 1 in HELD and RELEASE_CHK, and 0 otherwise.
REQ-025 Press latency from the first stable hit pass SHALL be exactly DEBOUNCE_SCANS passes (DEBOUNCE_SCANS*4*SCAN_DIV cycles, +/- one pass of phase) plus the synchronizer and strobe delay.

Reset
REQ-026 While rst is high, at the next edge: divider = 0, column index = 0, cols = 4'b1110, FSM = IDLE, counter = 0, pass registers cleared, key_code = 4'h0, key_valid = key_release = key_held = 0.
REQ-027 Reset asserted mid-press or mid-release SHALL abort with no strobe; a key still held after reset SHALL be re-accepted through the full debounce.

Structure
REQ-028 Shared package kypd_pkg SHALL hold the FSM state encoding, the 4x4 key-map table, and the SCAN_DIV / DEBOUNCE_SCANS defaults.
REQ-029 One sub-module, kypd_row_sync (4-bit 2-flop synchronizer, synchronous reset to all ones); the divider, scanner and FSM stay in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3; the bench keypad model pulls row r low while cols[c]=0 and key (r,c) is pressed)
REQ-030 Reset then idle 20 passes -> cols cycle 1110,1101,1011,0111 every 4 clks; all outputs remain 0.
REQ-031 Press key 5 (col1,row1) held -> single key_valid after the third hit pass, key_code=4'h5, key_held=1; release -> key_release after the third no-hit pass, key_held=0.
REQ-032 Press 9 with a one-pass drop-out after 2 passes, then stable -> key_valid only after 3 further consecutive hit passes; key_code=4'h9, exactly one strobe.
REQ-033 Press 1 and D together -> key_code=4'h1; in HELD, releasing 1 while D stays pressed -> no key_release, no new key_valid.
REQ-034 Assert rst during PRESS_CHK and during RELEASE_CHK -> no strobe; outputs equal reset values; a still-held key is re-accepted after 3 passes.
